// File: rtl/cmd_exec_burst.sv
// Byte-stream command executor: pops framed burst read/write commands from the RX FIFO,
// executes them against an internal register bank and pushes ACK/NAK plus read data to TX.
module cmd_exec_burst #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_fifo_valid,
    input  logic [7:0]  byte_fifo_data,
    output logic        byte_fifo_rd_en,
    output logic [7:0]  cmd_resp_wr_data,
    output logic        cmd_resp_wr_en,
    input  logic        cmd_resp_full,
    output logic        busy,
    output logic [15:0] err_cnt
);

    localparam int DATA_BYTES = DATA_W / 8;
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int ASH_W      = ADDR_BYTES * 8;
    localparam int SUM_W      = ADDR_W + 9;
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]       OP_WR      = 8'h57;
    localparam logic [7:0]       OP_RD      = 8'h52;
    localparam logic [7:0]       RSP_ACK    = 8'h06;
    localparam logic [7:0]       RSP_NAK    = 8'h15;
    localparam logic [7:0]       LAST_ABYTE = 8'(ADDR_BYTES - 1);
    localparam logic [7:0]       LAST_DBYTE = 8'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUM_W-1:0] DEPTH_EXT  = SUM_W'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_DRAIN,
        S_RFETCH, S_RSTATUS, S_RSEND, S_ACK, S_NAK
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_is_wr;
    logic               r_first;
    logic [ASH_W-1:0]   r_addr_sh;
    logic [7:0]         r_byte_cnt;
    logic [7:0]         r_words_left;
    logic [DATA_W-1:0]  r_wword;
    logic [DATA_W-1:0]  r_rshift;
    logic [TMO_W-1:0]   r_tmo;
    logic [15:0]        r_err_cnt;
    logic [DATA_W-1:0]  regs [0:DEPTH-1];

    logic [ADDR_W-1:0]  w_addr;
    logic [ASH_W-1:0]   w_ash_next;
    logic [DATA_W-1:0]  w_wword_next;
    logic [SUM_W-1:0]   w_end;
    logic               w_pop;
    logic               w_push;
    logic               w_tmo_state;
    logic               w_timeout;
    logic               w_len_bad;
    logic               w_last_byte;
    logic               w_last_word;

    assign w_addr       = r_addr_sh[ADDR_W-1:0];
    assign w_ash_next   = (r_addr_sh << 8) | ASH_W'(byte_fifo_data);
    assign w_wword_next = (r_wword << 8) | DATA_W'(byte_fifo_data);
    // Range check is done one bit wider than addr + 8-bit length so it can never wrap.
    assign w_end        = SUM_W'(w_addr) + SUM_W'(byte_fifo_data);
    assign w_len_bad    = (byte_fifo_data == 8'd0) || (w_end > DEPTH_EXT);
    assign w_last_byte  = (r_byte_cnt == LAST_DBYTE);
    assign w_last_word  = (r_words_left == 8'd1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state     = r_state;
        w_pop            = 1'b0;
        w_push           = 1'b0;
        w_tmo_state      = 1'b0;
        cmd_resp_wr_data = 8'h00;

        case (r_state)
            S_IDLE, S_ADDR, S_LEN, S_WDATA, S_DRAIN: w_pop = byte_fifo_valid && !rst;
            S_RSTATUS, S_RSEND, S_ACK, S_NAK:        w_push = !cmd_resp_full && !rst;
            default: ;
        endcase

        case (r_state)
            S_ADDR, S_LEN, S_WDATA, S_DRAIN: w_tmo_state = 1'b1;
            default: ;
        endcase
        w_timeout = w_tmo_state && !byte_fifo_valid && (r_tmo == TMO_LAST);

        case (r_state)
            S_ACK, S_RSTATUS: cmd_resp_wr_data = RSP_ACK;
            S_NAK:            cmd_resp_wr_data = RSP_NAK;
            S_RSEND:          cmd_resp_wr_data = r_rshift[DATA_W-1 -: 8];
            default: ;
        endcase

        case (r_state)
            S_IDLE: begin
                if (w_pop)
                    w_next_state = (byte_fifo_data == OP_WR || byte_fifo_data == OP_RD) ? S_ADDR : S_NAK;
            end
            S_ADDR: begin
                if (w_timeout)
                    w_next_state = S_NAK;
                else if (w_pop && r_byte_cnt == LAST_ABYTE)
                    w_next_state = S_LEN;
            end
            S_LEN: begin
                if (w_timeout)
                    w_next_state = S_NAK;
                else if (w_pop) begin
                    if (w_len_bad)
                        w_next_state = (r_is_wr && byte_fifo_data != 8'd0) ? S_DRAIN : S_NAK;
                    else
                        w_next_state = r_is_wr ? S_WDATA : S_RFETCH;
                end
            end
            S_WDATA: begin
                if (w_timeout)
                    w_next_state = S_NAK;
                else if (w_pop && w_last_byte && w_last_word)
                    w_next_state = S_ACK;
            end
            S_DRAIN: begin
                if (w_timeout || (w_pop && w_last_byte && w_last_word))
                    w_next_state = S_NAK;
            end
            S_RFETCH:  w_next_state = r_first ? S_RSTATUS : S_RSEND;
            S_RSTATUS: if (w_push) w_next_state = S_RSEND;
            S_RSEND: begin
                if (w_push && w_last_byte)
                    w_next_state = w_last_word ? S_IDLE : S_RFETCH;
            end
            S_ACK, S_NAK: if (w_push) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the bank is cleared by reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_wr      <= 1'b0;
            r_first      <= 1'b0;
            r_addr_sh    <= '0;
            r_byte_cnt   <= '0;
            r_words_left <= '0;
            r_wword      <= '0;
            r_rshift     <= '0;
            r_tmo        <= '0;
            r_err_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            // NOTE: non-blocking updates so every branch below sees pre-edge register values.
            r_state <= w_next_state;
            r_tmo   <= (w_tmo_state && !byte_fifo_valid) ? r_tmo + 1'b1 : '0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_is_wr    <= (byte_fifo_data == OP_WR);
                        r_byte_cnt <= '0;
                    end
                end
                S_ADDR: begin
                    if (w_pop) begin
                        r_addr_sh  <= w_ash_next;
                        r_byte_cnt <= (r_byte_cnt == LAST_ABYTE) ? 8'd0 : r_byte_cnt + 8'd1;
                    end
                end
                S_LEN: begin
                    if (w_pop) begin
                        r_words_left <= byte_fifo_data;
                        r_byte_cnt   <= '0;
                        r_first      <= 1'b1;
                    end
                end
                S_WDATA: begin
                    if (w_pop) begin
                        r_wword <= w_wword_next;
                        if (w_last_byte) begin
                            regs[w_addr] <= w_wword_next;
                            r_addr_sh    <= r_addr_sh + ASH_W'(1);
                            r_words_left <= r_words_left - 8'd1;
                            r_byte_cnt   <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        if (w_last_byte) begin
                            r_words_left <= r_words_left - 8'd1;
                            r_byte_cnt   <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                        end
                    end
                end
                S_RFETCH: begin
                    r_rshift   <= regs[w_addr];
                    r_addr_sh  <= r_addr_sh + ASH_W'(1);
                    r_byte_cnt <= '0;
                    r_first    <= 1'b0;
                end
                S_RSEND: begin
                    if (w_push) begin
                        r_rshift <= r_rshift << 8;
                        if (w_last_byte) begin
                            r_words_left <= r_words_left - 8'd1;
                            r_byte_cnt   <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                        end
                    end
                end
                S_NAK: begin
                    if (w_push && r_err_cnt != 16'hFFFF)
                        r_err_cnt <= r_err_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign byte_fifo_rd_en = w_pop;
    assign cmd_resp_wr_en  = w_push;
    assign busy            = (r_state != S_IDLE);
    assign err_cnt         = r_err_cnt;

endmodule
